// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler
// Brief    : Highway/farm-road phase sequencer with request latching,
//            emergency preemption and tick-timed phase durations.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
  parameter int TIME_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Tick_i,
  input  logic [TIME_W-1:0] ShortTime_i,
  input  logic [TIME_W-1:0] LongTime_i,
  input  logic              FarmCar_i,
  input  logic              PedReq_i,
  input  logic              Emerg_i,
  output logic              HG,
  output logic              HY,
  output logic              HR,
  output logic              FG,
  output logic              FY,
  output logic              FR,
  output logic              Walk_o,
  output logic [2:0]        Phase_o
);

  typedef enum logic [2:0] {
    HWY_GRN  = 3'd0,
    HWY_YEL  = 3'd1,
    ALL_RED1 = 3'd2,
    FARM_GRN = 3'd3,
    FARM_YEL = 3'd4,
    ALL_RED2 = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TIME_W-1:0] r_cnt;
  logic [TIME_W-1:0] r_dur;
  logic [TIME_W-1:0] w_dur_next;
  logic              r_car_pend;
  logic              r_ped_pend;
  logic              r_walk_latch;
  logic              w_done;
  logic              w_enter;
  logic              w_enter_fg;

  // Done either because the counter already reached dur, or it reaches it on this tick.
  assign w_done     = (r_cnt == r_dur) || (Tick_i && (r_cnt == (r_dur - TIME_W'(1))));
  assign w_enter    = (w_next != r_state);
  assign w_enter_fg = w_enter && (w_next == FARM_GRN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      HWY_GRN:  if (w_done && (r_car_pend || r_ped_pend) && !Emerg_i) w_next = HWY_YEL;
      HWY_YEL:  if (w_done) w_next = ALL_RED1;
      ALL_RED1: if (w_done) w_next = FARM_GRN;
      FARM_GRN: if (Emerg_i || w_done) w_next = FARM_YEL;
      FARM_YEL: if (w_done) w_next = ALL_RED2;
      ALL_RED2: if (w_done) w_next = HWY_GRN;
      default:  w_next = HWY_GRN;
    endcase
  end

  always_comb begin
    w_dur_next = TIME_W'(1);
    case (w_next)
      HWY_GRN, FARM_GRN: if (LongTime_i != '0) w_dur_next = LongTime_i;
      HWY_YEL, FARM_YEL: if (ShortTime_i != '0) w_dur_next = ShortTime_i;
      default:           w_dur_next = TIME_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HWY_GRN;
      r_cnt        <= '0;
      r_dur        <= '0;
      r_car_pend   <= 1'b0;
      r_ped_pend   <= 1'b0;
      r_walk_latch <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter) begin
        r_cnt <= '0;
        r_dur <= w_dur_next;
      end else if (Tick_i && (r_cnt < r_dur)) begin
        r_cnt <= r_cnt + TIME_W'(1);
      end
      // A new request on the clearing edge survives into the next cycle.
      r_car_pend <= FarmCar_i | (r_car_pend & ~w_enter_fg);
      r_ped_pend <= PedReq_i  | (r_ped_pend & ~w_enter_fg);
      if (w_enter_fg) r_walk_latch <= r_ped_pend;
    end
  end

  always_comb begin
    HG     = 1'b0;
    HY     = 1'b0;
    HR     = 1'b0;
    FG     = 1'b0;
    FY     = 1'b0;
    FR     = 1'b0;
    Walk_o = 1'b0;
    case (r_state)
      HWY_GRN:  begin HG = 1'b1; FR = 1'b1; end
      HWY_YEL:  begin HY = 1'b1; FR = 1'b1; end
      FARM_GRN: begin HR = 1'b1; FG = 1'b1; Walk_o = r_walk_latch; end
      FARM_YEL: begin HR = 1'b1; FY = 1'b1; end
      default:  begin HR = 1'b1; FR = 1'b1; end
    endcase
  end

  assign Phase_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// each cycle compared against a tick-accounting phase model.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Tick_i = 1'b0;
  logic [5:0] ShortTime_i = 6'd3;
  logic [5:0] LongTime_i = 6'd5;
  logic       FarmCar_i = 1'b0;
  logic       PedReq_i = 1'b0;
  logic       Emerg_i = 1'b0;
  logic       HG, HY, HR, FG, FY, FR, Walk_o;
  logic [2:0] Phase_o;
  logic [9:0] obs;

  int total = 0;
  int bad = 0;

  traffic_phase_scheduler #(.TIME_W(6)) dut (
    .clk(clk), .rst(rst), .Tick_i(Tick_i), .ShortTime_i(ShortTime_i),
    .LongTime_i(LongTime_i), .FarmCar_i(FarmCar_i), .PedReq_i(PedReq_i),
    .Emerg_i(Emerg_i), .HG(HG), .HY(HY), .HR(HR), .FG(FG), .FY(FY), .FR(FR),
    .Walk_o(Walk_o), .Phase_o(Phase_o)
  );

  always #5 clk = ~clk;
  assign obs = {HG, HY, HR, FG, FY, FR, Walk_o, Phase_o};

  // Model: phase index, ticks seen since phase entry (unbounded), phase length in ticks.
  int m_phase = 0;
  int m_ticks = 0;
  int m_dur = 0;
  bit m_car = 0, m_ped = 0, m_walk = 0;
  int hist[$];
  int run_ph[$];
  int run_len[$];

  function automatic int at_least_one(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge();
    int nxt;
    bit done;
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_dur = 0; m_car = 0; m_ped = 0; m_walk = 0;
    end else begin
      done = (m_ticks + int'(Tick_i)) >= m_dur;
      nxt = m_phase;
      if (m_phase == 3 && Emerg_i) nxt = 4;
      else if (m_phase == 0) begin
        if (done && (m_car || m_ped) && !Emerg_i) nxt = 1;
      end else if (done) nxt = (m_phase + 1) % 6;
      if (nxt == 3 && m_phase != 3) begin
        m_walk = m_ped;
        m_car = FarmCar_i;
        m_ped = PedReq_i;
      end else begin
        m_car = m_car | FarmCar_i;
        m_ped = m_ped | PedReq_i;
      end
      if (nxt != m_phase) begin
        if (nxt == 0 || nxt == 3) m_dur = at_least_one(int'(LongTime_i));
        else if (nxt == 1 || nxt == 4) m_dur = at_least_one(int'(ShortTime_i));
        else m_dur = 1;
        m_ticks = 0;
      end else begin
        m_ticks = m_ticks + int'(Tick_i);
      end
      m_phase = nxt;
    end
  endtask

  function automatic logic [9:0] exp_out();
    logic [5:0] l;
    case (m_phase)
      0:       l = 6'b100001;
      1:       l = 6'b010001;
      3:       l = 6'b001100;
      4:       l = 6'b001010;
      default: l = 6'b001001;
    endcase
    return {l, (m_phase == 3) && m_walk, 3'(m_phase)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    hist.push_back(int'(Phase_o));
  endtask

  task automatic build_runs();
    run_ph.delete();
    run_len.delete();
    foreach (hist[i]) begin
      if (run_ph.size() != 0 && run_ph[run_ph.size()-1] == hist[i])
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
      else begin
        run_ph.push_back(hist[i]);
        run_len.push_back(1);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; FarmCar_i = 0; PedReq_i = 0; Emerg_i = 0;
    step(); step();
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic test_reset();
    Tick_i = 1; ShortTime_i = 6'd3; LongTime_i = 6'd5;
    do_reset();
    total++;
    if (obs !== 10'b100001_0_000) begin
      bad++; $display("FAIL reset_state got=%b want=%b", obs, 10'b100001_0_000);
    end
    for (int i = 0; i < 50; i++) begin
      step();
      total++;
      if (obs !== exp_out() || Phase_o !== 3'd0) begin
        bad++; $display("FAIL idle_hold cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
  endtask

  task automatic test_car_sequence();
    int walk_seen = 0;
    Tick_i = 1; ShortTime_i = 6'd3; LongTime_i = 6'd5;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      FarmCar_i = (i == 2);
      step();
      if (Walk_o) walk_seen++;
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL car_seq cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
    FarmCar_i = 0;
    build_runs();
    total++;
    if (run_ph.size() != 7 || run_ph[6] != 0) begin
      bad++; $display("FAIL car_runs got=%0d runs want=7 ending in HWY_GRN", run_ph.size());
    end else begin
      for (int r = 1; r <= 5; r++) begin
        int want;
        want = (r == 1 || r == 4) ? 3 : (r == 3) ? 5 : 1;
        total++;
        if (run_ph[r] != r || run_len[r] != want) begin
          bad++; $display("FAIL car_len phase=%0d got=%0d want=%0d", run_ph[r], run_len[r], want);
        end
      end
    end
    total++;
    if (walk_seen != 0) begin
      bad++; $display("FAIL car_walk got=%0d want=0", walk_seen);
    end
  endtask

  task automatic test_ped_walk();
    int n = 0;
    int walk_cnt = 0;
    int fg_entries = 0;
    int prev;
    Tick_i = 1; ShortTime_i = 6'd3; LongTime_i = 6'd5;
    do_reset();
    PedReq_i = 1; step(); PedReq_i = 0;
    while (Phase_o != 3'd2 && n < 60) begin step(); n++; end
    total++;
    if (n >= 60) begin
      bad++; $display("FAIL ped_timeout got=%0d want=2", Phase_o);
    end
    PedReq_i = 1;
    prev = int'(Phase_o);
    for (int i = 0; i < 40; i++) begin
      step();
      PedReq_i = 0;
      if (Walk_o) walk_cnt++;
      if (Phase_o == 3'd3 && prev != 3) fg_entries++;
      prev = int'(Phase_o);
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL ped_cyc cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
    total++;
    if (walk_cnt != 10 || fg_entries != 2) begin
      bad++; $display("FAIL ped_walk got walk=%0d fg=%0d want walk=10 fg=2", walk_cnt, fg_entries);
    end
  endtask

  task automatic test_emergency();
    int n = 0;
    Tick_i = 1; ShortTime_i = 6'd3; LongTime_i = 6'd5;
    do_reset();
    FarmCar_i = 1; PedReq_i = 1; Emerg_i = 1;
    step();
    FarmCar_i = 0; PedReq_i = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (Phase_o !== 3'd0 || obs !== exp_out()) begin
        bad++; $display("FAIL emerg_hold cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
    Emerg_i = 0;
    step();
    total++;
    if (Phase_o !== 3'd1 || obs !== exp_out()) begin
      bad++; $display("FAIL emerg_release got=%0d want=1", Phase_o);
    end
    while (Phase_o != 3'd3 && n < 30) begin step(); n++; end
    total++;
    if (n >= 30) begin
      bad++; $display("FAIL emerg_timeout got=%0d want=3", Phase_o);
    end
    step();
    Emerg_i = 1;
    step();
    Emerg_i = 0;
    total++;
    if (Phase_o !== 3'd4 || Walk_o !== 1'b0 || obs !== exp_out()) begin
      bad++; $display("FAIL emerg_cut got=%b want=%b", obs, 10'b001010_0_100);
    end
  endtask

  task automatic test_slow_tick();
    int fg_idx;
    Tick_i = 1; ShortTime_i = 6'd0; LongTime_i = 6'd5;
    do_reset();
    for (int k = 0; k < 150; k++) begin
      Tick_i = (k % 4 == 0);
      FarmCar_i = (k == 1) || (Phase_o == 3'd4);
      if (Phase_o == 3'd3) LongTime_i = 6'd9;
      step();
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL slow_cyc cyc=%0d got=%b want=%b", k, obs, exp_out());
      end
    end
    FarmCar_i = 0; Tick_i = 1;
    build_runs();
    fg_idx = -1;
    foreach (run_ph[i]) if (run_ph[i] == 3 && fg_idx < 0) fg_idx = i;
    total++;
    if (fg_idx < 0 || fg_idx + 3 >= run_ph.size()) begin
      bad++; $display("FAIL slow_runs got=%0d runs want FG then FY,AR,HG", run_ph.size());
    end else if (run_len[fg_idx] != 20 || run_len[fg_idx+1] != 4 || run_len[fg_idx+3] != 36) begin
      bad++;
      $display("FAIL slow_len got fg=%0d fy=%0d hg=%0d want fg=20 fy=4 hg=36",
               run_len[fg_idx], run_len[fg_idx+1], run_len[fg_idx+3]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    Tick_i = 1; ShortTime_i = 6'd3; LongTime_i = 6'd5;
    do_reset();
    FarmCar_i = 1; step(); FarmCar_i = 0;
    while (Phase_o != 3'd4 && n < 40) begin step(); n++; end
    FarmCar_i = 1; PedReq_i = 1;
    step();
    FarmCar_i = 0; PedReq_i = 0;
    rst = 1;
    step();
    rst = 0;
    total++;
    if (obs !== 10'b100001_0_000) begin
      bad++; $display("FAIL reset_mid got=%b want=%b", obs, 10'b100001_0_000);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      total++;
      if (Phase_o !== 3'd0 || obs !== exp_out()) begin
        bad++; $display("FAIL reset_clears cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      Tick_i      = ($urandom_range(0, 2) != 0);
      ShortTime_i = 6'($urandom_range(0, 4));
      LongTime_i  = 6'($urandom_range(0, 7));
      FarmCar_i   = ($urandom_range(0, 29) == 0);
      PedReq_i    = ($urandom_range(0, 39) == 0);
      Emerg_i     = ($urandom_range(0, 24) == 0);
      step();
      total++;
      if (obs !== exp_out()) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
    rst = 0; FarmCar_i = 0; PedReq_i = 0; Emerg_i = 0;
  endtask

  initial begin
    test_reset();
    test_car_sequence();
    test_ped_walk();
    test_emergency();
    test_slow_tick();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
